// File: rtl/mavg_pkg.sv
// Shared definitions for the moving-sum encoder/decoder pair.
// Both sides take ACC_WIDTH from acc_width() so their sum widths always agree.
package mavg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } mavg_state_e;

    // Window sum of 2^n samples of dw bits needs n extra bits
    function automatic int unsigned acc_width(input int unsigned n, input int unsigned dw);
        return dw + n;
    endfunction

endpackage

// File: rtl/mavg_history_ring.sv
// N-entry sample history for the moving-sum decoder: the slot at the write pointer
// always holds the oldest sample, which is read and then overwritten on each write.
module mavg_history_ring #(
    parameter int unsigned n          = 3,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** n;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [n-1:0]          r_wr_ptr;

    assign rdata = r_mem[r_wr_ptr];

    // Pointer wraps N-1 -> 0 by natural overflow of its n bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (clear) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (we) begin
            r_mem[r_wr_ptr] <= wdata;
            r_wr_ptr        <= r_wr_ptr + n'(1);
        end
    end

endmodule

// File: rtl/moving_sum_decoder.sv
// Moving-sum decoder: recovers x[k] = S[k] - S[k-1] + x[k-N] from a stream of window sums.
// Optional range check enabled by defining MOVING_SUM_DECODER_RANGE_CHECK_EN.
module moving_sum_decoder
    import mavg_pkg::*;
#(
    parameter  int unsigned n          = 3,
    parameter  int unsigned DATA_WIDTH = 16,
    localparam int unsigned ACC_WIDTH  = acc_width(n, DATA_WIDTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         sum_valid,
    output logic                         sum_ready,
    input  logic signed [ACC_WIDTH-1:0]  sum_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] sample_out,
    output logic                         err
);

    mavg_state_e                  r_state;
    logic                         r_out_valid;
    logic signed [DATA_WIDTH-1:0] r_sample;
    logic                         r_err;
    logic signed [ACC_WIDTH-1:0]  r_prev_sum;

    logic                         w_accept;
    logic                         w_ring_we;
    logic [DATA_WIDTH-1:0]        w_oldest;
    logic signed [ACC_WIDTH:0]    w_diff;
    logic signed [ACC_WIDTH+1:0]  w_res;
    logic [DATA_WIDTH-1:0]        w_sample;
    logic                         w_range_fail;

    assign sum_ready  = (r_state != HALT) && (!r_out_valid || out_ready);
    assign w_accept   = sum_valid && sum_ready;
    assign w_ring_we  = w_accept && !clear;
    assign out_valid  = r_out_valid;
    assign sample_out = r_sample;
    assign err        = r_err;

    mavg_history_ring #(
        .n          (n),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ring (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .we    (w_ring_we),
        .wdata (w_sample),
        .rdata (w_oldest)
    );

    // Widened so neither the difference nor the re-added history sample can overflow
    assign w_diff   = $signed({sum_in[ACC_WIDTH-1], sum_in})
                    - $signed({r_prev_sum[ACC_WIDTH-1], r_prev_sum});
    assign w_res    = $signed({w_diff[ACC_WIDTH], w_diff})
                    + $signed({{(ACC_WIDTH+2-DATA_WIDTH){w_oldest[DATA_WIDTH-1]}}, w_oldest});
    assign w_sample = w_res[DATA_WIDTH-1:0];

`ifdef MOVING_SUM_DECODER_RANGE_CHECK_EN
    // In range only if every bit above the data sign bit copies it
    assign w_range_fail = !((&w_res[ACC_WIDTH+1:DATA_WIDTH-1]) || !(|w_res[ACC_WIDTH+1:DATA_WIDTH-1]));
`else
    logic w_unused_hi;
    assign w_unused_hi  = ^w_res[ACC_WIDTH+1:DATA_WIDTH];
    assign w_range_fail = 1'b0;
`endif

    // FSM, output register and previous-sum register; clear wins over accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_sample    <= '0;
            r_err       <= 1'b0;
            r_prev_sum  <= '0;
        end else if (clear) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_sample    <= '0;
            r_err       <= 1'b0;
            r_prev_sum  <= '0;
        end else begin
            if (w_accept) begin
                r_sample    <= w_sample;
                r_out_valid <= 1'b1;
                r_prev_sum  <= sum_in;
                if (w_range_fail) begin
                    r_err   <= 1'b1;
                    r_state <= HALT;
                end else if (r_state == IDLE) begin
                    r_state <= RUN;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_moving_sum_decoder.sv
// Self-checking bench for moving_sum_decoder (n=3, DATA_WIDTH=16): table-driven streams
// plus directed stall, clear, range and reset sequences, checked through a scoreboard queue.
module tb_moving_sum_decoder;
    import mavg_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 19;

    typedef struct {
        logic signed [AW-1:0] sum;
        logic signed [DW-1:0] exp;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 clear;
    logic                 sum_valid;
    logic                 sum_ready;
    logic signed [AW-1:0] sum_in;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] sample_out;
    logic                 err;

    logic signed [DW-1:0] q[$];
    logic signed [DW-1:0] drv_exp;
    vec_t                 tbl[10];
    int                   n_cmp = 0;
    int                   n_bad = 0;
    time                  t0;

    always #5 clk = ~clk;

    moving_sum_decoder #(.n(3), .DATA_WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .sum_in     (sum_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sample_out (sample_out),
        .err        (err)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int s, input int e);
        vec_t v;
        v.sum = AW'(s);
        v.exp = DW'(e);
        return v;
    endfunction

    // Scoreboard: pop on output handshake, push on input handshake, flush on reset
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output: got %0d, expected none (t=%0t)", sample_out, $time);
                    end else begin
                        check("sample_out", sample_out, q.pop_front());
                    end
                end
                if (sum_valid && sum_ready && !clear) q.push_back(drv_exp);
            end
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send(input vec_t v);
        bit ok;
        int t;
        ok = 1'b0;
        t  = 0;
        sum_valid = 1'b1;
        sum_in    = v.sum;
        drv_exp   = v.exp;
        while (!ok && t < 20) begin
            #3 ok = sum_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got no accept, expected accept of %0d", v.sum);
        end
    endtask

    task automatic idle(input int k);
        sum_valid = 1'b0;
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        sum_valid = 1'b0;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        int sums[10] = '{1, 3, 6, 10, 15, 21, 28, 36, 44, 52};
        reset = 1'b1; clear = 1'b0; sum_valid = 1'b0; sum_in = '0;
        out_ready = 1'b1; drv_exp = '0;
        for (int i = 0; i < 10; i++) tbl[i] = mk(sums[i], i + 1);
        fork
            monitor();
        join_none

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_sample_out", sample_out, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1 reset = 1'b0;
        check("idle_sum_ready", sum_ready, 1);
        check("idle_state", dut.r_state, IDLE);

        // Full-rate stream, latency 1
        t0 = $time;
        for (int i = 0; i < 10; i++) begin
            send(tbl[i]);
            if (i == 0) begin
                check("lat1_valid", out_valid, 1);
                check("lat1_sample", sample_out, 1);
            end
        end
        check("throughput_ns", longint'($time - t0), 100);
        idle(2);
        check("drain_q", q.size(), 0);
        check("drain_valid", out_valid, 0);
        check("run_state", dut.r_state, RUN);

        // Backpressure at sample 5
        do_clear();
        for (int i = 0; i < 5; i++) send(tbl[i]);
        out_ready = 1'b0;
        sum_valid = 1'b1; sum_in = tbl[5].sum; drv_exp = tbl[5].exp;
        repeat (3) begin
            #3;
            check("stall_sample", sample_out, 5);
            check("stall_valid", out_valid, 1);
            check("stall_ready", sum_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 5; i < 10; i++) send(tbl[i]);
        idle(2);
        check("stall_q", q.size(), 0);

        // Clear with a pending sum: clear wins, history restarts at zero
        do_clear();
        for (int i = 0; i < 6; i++) send(tbl[i]);
        clear = 1'b1; sum_valid = 1'b1; sum_in = AW'(2);
        @(posedge clk); #1;
        clear = 1'b0; sum_valid = 1'b0;
        check("clr_valid", out_valid, 0);
        check("clr_state", dut.r_state, IDLE);
        send(mk(2, 2));
        check("clr_run", dut.r_state, RUN);
        send(mk(5, 3));
        idle(2);
        check("clr_q", q.size(), 0);

        // Negative data
        do_clear();
        send(mk(-4, -4));
        send(mk(-4, 0));
        send(mk(-4, 0));
        idle(2);

        // Out-of-range sample: truncated output, optional halt
        do_clear();
        send(mk(0, 0));
        send(mk(40000, -25536));
`ifdef MOVING_SUM_DECODER_RANGE_CHECK_EN
        check("rng_err", err, 1);
        check("rng_ready", sum_ready, 0);
        check("rng_state", dut.r_state, HALT);
        sum_valid = 1'b1; sum_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("halt_drained", out_valid, 0);
        check("halt_ready", sum_ready, 0);
        check("halt_err", err, 1);
        do_clear();
        check("halt_clr_err", err, 0);
        check("halt_clr_ready", sum_ready, 1);
        check("halt_clr_state", dut.r_state, IDLE);
`else
        check("rng_err", err, 0);
        check("rng_ready", sum_ready, 1);
        check("rng_state", dut.r_state, RUN);
`endif
        idle(2);
        check("rng_q", q.size(), 0);

        // Asynchronous reset mid-stream drops the held sample
        do_clear();
        send(mk(1, 1));
        send(mk(3, 2));
        sum_valid = 1'b0; out_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_sample", sample_out, 0);
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        send(mk(1, 1));
        send(mk(3, 2));
        idle(2);
        check("arst_q", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
